// File: rtl/fbuf_sprite_blit.sv
// Chip-8 DXYN sprite blitter: XOR-draws sprite rows into a 128x64 word framebuffer.
// Define FBUF_SPRITE_WRAP_EN to wrap at screen edges instead of clipping.
module fbuf_sprite_blit #(
  parameter int unsigned SPR_AW = 5
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              hires,
  input  logic [6:0]        pos_x,
  input  logic [5:0]        pos_y,
  input  logic [3:0]        rows,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic [SPR_AW-1:0] spr_addr,
  input  logic [7:0]        spr_data,
  output logic [8:0]        fb_addr,
  input  logic [15:0]       fb_rdata,
  output logic [15:0]       fb_wdata,
  output logic              fb_we
);

`ifdef FBUF_SPRITE_WRAP_EN
  localparam bit Wrap = 1'b1;
`else
  localparam bit Wrap = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle, StFetch0, StFetch1, StRdL, StRdR, StWrL, StWrR, StNext
  } state_e;

  state_e            state_q, state_d;
  logic              hires_q, hires_d;
  logic [6:0]        x_q, x_d;
  logic [6:0]        row_q, row_d;
  logic [3:0]        rows_q, rows_d;
  logic [3:0]        r_q, r_d;
  logic              sub_q, sub_d;
  logic [7:0]        byte0_q, byte0_d, byte1_q, byte1_d;
  logic              cap0_q, cap0_d, cap1_q, cap1_d;
  logic [15:0]       old_l_q, old_l_d, old_r_q, old_r_d;
  logic              busy_q, busy_d, done_q, done_d, collision_q, collision_d;
  logic [SPR_AW-1:0] spr_addr_q, spr_addr_d;
  logic [8:0]        fb_addr_q, fb_addr_d;
  logic              fb_we_q, fb_we_d;

  logic        wide, wide_n, last_row, skip_r;
  logic [2:0]  word_l, word_r;
  logic [6:0]  row_inc;
  logic [15:0] dbl, pat, wr_old, wr_pat;
  logic [31:0] span;

  assign wide     = hires_q && (rows_q == 4'd0);
  assign last_row = (r_q == rows_q - 4'd1);
  assign word_l   = x_q[6:4];
  assign word_r   = word_l + 3'd1;
  assign skip_r   = (x_q[3:0] == 4'd0) || (!Wrap && (word_l == 3'd7));
  assign row_inc  = row_q + 7'd1;

  // Row pattern: lores doubles each sprite bit, then the pattern is placed across words L and R.
  always_comb begin
    dbl = '0;
    for (int i = 0; i < 8; i++) begin
      dbl[2*i]   = byte0_q[i];
      dbl[2*i+1] = byte0_q[i];
    end
    if (!hires_q)  pat = dbl;
    else if (wide) pat = {byte0_q, byte1_q};
    else           pat = {byte0_q, 8'h00};
    span = {pat, 16'h0000} >> x_q[3:0];
  end

  // With R skipped the L read data arrives directly in WR_L; otherwise it was held from RD_R.
  always_comb begin
    wr_old = '0;
    wr_pat = '0;
    if (state_q == StWrL) begin
      wr_old = skip_r ? fb_rdata : old_l_q;
      wr_pat = span[31:16];
    end else if (state_q == StWrR) begin
      wr_old = old_r_q;
      wr_pat = span[15:0];
    end
  end

  assign fb_wdata = wr_old ^ wr_pat;

  always_comb begin
    state_d     = state_q;
    hires_d     = hires_q;
    x_d         = x_q;
    row_d       = row_q;
    rows_d      = rows_q;
    r_d         = r_q;
    sub_d       = sub_q;
    old_l_d     = old_l_q;
    old_r_d     = old_r_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    collision_d = collision_q;
    cap0_d      = (state_q == StFetch0);
    cap1_d      = (state_q == StFetch1);
    byte0_d     = cap0_q ? spr_data : byte0_q;
    byte1_d     = cap1_q ? spr_data : byte1_q;

    unique case (state_q)
      StIdle: begin
        // The done cycle still counts as busy for start acceptance.
        if (start && !done_q) begin
          hires_d     = hires;
          x_d         = hires ? pos_x : {pos_x[5:0], 1'b0};
          row_d       = hires ? {1'b0, pos_y} : {1'b0, pos_y[4:0], 1'b0};
          rows_d      = rows;
          r_d         = 4'd0;
          sub_d       = 1'b0;
          collision_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = StFetch0;
        end
      end
      StFetch0: state_d = wide ? StFetch1 : StRdL;
      StFetch1: state_d = StRdL;
      StRdL:    state_d = skip_r ? StWrL : StRdR;
      StRdR: begin
        old_l_d = fb_rdata;
        state_d = StWrL;
      end
      StWrL: begin
        old_r_d = fb_rdata;
        if (|(wr_old & wr_pat)) collision_d = 1'b1;
        state_d = skip_r ? StNext : StWrR;
      end
      StWrR: begin
        if (|(wr_old & wr_pat)) collision_d = 1'b1;
        state_d = StNext;
      end
      StNext: begin
        row_d = row_inc;
        if (!hires_q && !sub_q) begin
          sub_d   = 1'b1;
          state_d = StRdL;
        end else begin
          sub_d   = 1'b0;
          r_d     = r_q + 4'd1;
          state_d = StFetch0;
        end
        // Rows only increase, so the first clipped row ends the draw.
        if (((hires_q || sub_q) && last_row) || (!Wrap && row_inc[6])) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    wide_n     = hires_d && (rows_d == 4'd0);
    spr_addr_d = spr_addr_q;
    if (state_d == StFetch0)      spr_addr_d = wide_n ? SPR_AW'({r_d, 1'b0}) : SPR_AW'(r_d);
    else if (state_d == StFetch1) spr_addr_d = SPR_AW'({r_d, 1'b1});

    fb_addr_d = fb_addr_q;
    if (state_d == StRdL || state_d == StWrL)      fb_addr_d = {row_d[5:0], word_l};
    else if (state_d == StRdR || state_d == StWrR) fb_addr_d = {row_d[5:0], word_r};
    fb_we_d = (state_d == StWrL) || (state_d == StWrR);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= StIdle;
      hires_q     <= 1'b0;
      x_q         <= '0;
      row_q       <= '0;
      rows_q      <= '0;
      r_q         <= '0;
      sub_q       <= 1'b0;
      byte0_q     <= '0;
      byte1_q     <= '0;
      cap0_q      <= 1'b0;
      cap1_q      <= 1'b0;
      old_l_q     <= '0;
      old_r_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      collision_q <= 1'b0;
      spr_addr_q  <= '0;
      fb_addr_q   <= '0;
      fb_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hires_q     <= hires_d;
      x_q         <= x_d;
      row_q       <= row_d;
      rows_q      <= rows_d;
      r_q         <= r_d;
      sub_q       <= sub_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      cap0_q      <= cap0_d;
      cap1_q      <= cap1_d;
      old_l_q     <= old_l_d;
      old_r_q     <= old_r_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      collision_q <= collision_d;
      spr_addr_q  <= spr_addr_d;
      fb_addr_q   <= fb_addr_d;
      fb_we_q     <= fb_we_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign collision = collision_q;
  assign spr_addr  = spr_addr_q;
  assign fb_addr   = fb_addr_q;
  assign fb_we     = fb_we_q;

endmodule

// File: tb/tb_fbuf_sprite_blit.sv
// Scoreboard bench for fbuf_sprite_blit: a pixel-level model predicts every framebuffer write
// and the collision flag; a negedge monitor compares them as the DUT produces them.
module tb_fbuf_sprite_blit;

`ifdef FBUF_SPRITE_WRAP_EN
  localparam bit Wrap = 1'b1;
`else
  localparam bit Wrap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        start = 1'b0;
  logic        hires = 1'b0;
  logic [6:0]  pos_x = '0;
  logic [5:0]  pos_y = '0;
  logic [3:0]  rows = '0;
  logic        busy, done, collision, fb_we;
  logic [4:0]  spr_addr;
  logic [7:0]  spr_data = '0;
  logic [8:0]  fb_addr;
  logic [15:0] fb_rdata = '0;
  logic [15:0] fb_wdata;

  logic [15:0] fb_mem   [512];
  logic [15:0] model_fb [512];
  logic [7:0]  spr_mem  [32];
  logic [24:0] exp_wr_q [$];
  bit          exp_col_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  fbuf_sprite_blit #(.SPR_AW(5)) dut (
    .clk(clk), .res(res), .start(start), .hires(hires), .pos_x(pos_x), .pos_y(pos_y),
    .rows(rows), .busy(busy), .done(done), .collision(collision), .spr_addr(spr_addr),
    .spr_data(spr_data), .fb_addr(fb_addr), .fb_rdata(fb_rdata), .fb_wdata(fb_wdata),
    .fb_we(fb_we)
  );

  always #5 clk = ~clk;

  // Synchronous memories with 1-cycle read latency; read returns pre-write data.
  always @(posedge clk) begin
    fb_rdata <= fb_mem[fb_addr];
    spr_data <= spr_mem[spr_addr];
    if (fb_we) fb_mem[fb_addr] = fb_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fb();
    for (int i = 0; i < 512; i++) begin
      fb_mem[i]   = '0;
      model_fb[i] = '0;
    end
  endtask

  // Reference: plot each lit sprite pixel at screen coordinates, then XOR touched words.
  task automatic model_draw(input bit h, input logic [6:0] px, input logic [5:0] py,
                            input logic [3:0] n);
    int xs, ys, nr, spx, reps, wl, nwords;
    bit wide, col;
    logic [127:0] line;
    xs   = h ? int'(px) : 2 * int'(px[5:0]);
    ys   = h ? int'(py) : 2 * int'(py[4:0]);
    nr   = (n == 4'd0) ? 16 : int'(n);
    wide = h && (n == 4'd0);
    spx  = wide ? 16 : 8;
    reps = h ? 1 : 2;
    col  = 1'b0;
    wl   = xs / 16;
    nwords = ((xs % 16) != 0 && (Wrap || wl != 7)) ? 2 : 1;
    for (int sr = 0; sr < nr; sr++) begin
      for (int dy = 0; dy < reps; dy++) begin
        int y;
        y = ys + sr * reps + dy;
        if (Wrap || y < 64) begin
          line = '0;
          for (int c = 0; c < spx; c++) begin
            logic [7:0] b;
            b = wide ? spr_mem[2 * sr + c / 8] : spr_mem[sr];
            if (b[7 - c % 8]) begin
              for (int d = 0; d < reps; d++) begin
                int x;
                x = xs + (h ? c : 2 * c + d);
                if (Wrap || x < 128) line[x % 128] = 1'b1;
              end
            end
          end
          for (int k = 0; k < nwords; k++) begin
            int w, a;
            logic [15:0] p, old;
            w = (wl + k) % 8;
            for (int j = 0; j < 16; j++) p[15 - j] = line[16 * w + j];
            a = (y % 64) * 8 + w;
            old = model_fb[a];
            if ((old & p) != 16'h0) col = 1'b1;
            model_fb[a] = old ^ p;
            exp_wr_q.push_back({9'(a), old ^ p});
          end
        end
      end
    end
    exp_col_q.push_back(col);
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      tick();
      if (done) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic run_draw(input bit h, input logic [6:0] px, input logic [5:0] py,
                          input logic [3:0] n, input bit poke);
    model_draw(h, px, py, n);
    hires = h; pos_x = px; pos_y = py; rows = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (poke) begin
      repeat (3) tick();
      check("busy_during_draw", 32'(busy), 32'd1);
      hires = ~h; pos_x = px + 7'd5; pos_y = py + 6'd7; rows = n + 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_done();
  endtask

  always @(negedge clk) begin
    if (!res) begin
      if (fb_we) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL fb_write: got write addr %0d data %h, expected no write", fb_addr,
                   fb_wdata);
        end else begin
          logic [24:0] e;
          e = exp_wr_q.pop_front();
          check("fb_write", {7'd0, fb_addr, fb_wdata}, {7'd0, e});
        end
      end
      if (done) begin
        check("busy_low_at_done", 32'(busy), 32'd0);
        check("writes_left_at_done", 32'(exp_wr_q.size()), 32'd0);
        if (exp_col_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_pulse: got done=1, expected no draw in progress");
        end else begin
          bit ec;
          ec = exp_col_q.pop_front();
          check("collision", 32'(collision), 32'(ec));
        end
      end
    end
  end

  initial begin
    int mism;
    clear_fb();
    for (int i = 0; i < 32; i++) spr_mem[i] = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_collision", 32'(collision), 32'd0);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_wdata", 32'(fb_wdata), 32'd0);
    check("rst_spr_addr", 32'(spr_addr), 32'd0);
    res = 1'b0;
    tick();

    spr_mem[0] = 8'hF0;
    run_draw(1'b1, 7'd0, 6'd0, 4'd1, 1'b0);
    check("basic_word0", 32'(fb_mem[0]), 32'h0000_F000);
    check("basic_collision", 32'(collision), 32'd0);
    run_draw(1'b1, 7'd0, 6'd0, 4'd1, 1'b0);
    check("erase_word0", 32'(fb_mem[0]), 32'd0);
    check("erase_collision", 32'(collision), 32'd1);

    clear_fb();
    spr_mem[0] = 8'hFF;
    run_draw(1'b1, 7'd12, 6'd3, 4'd1, 1'b0);
    check("straddle_l", 32'(fb_mem[24]), 32'h0000_000F);
    check("straddle_r", 32'(fb_mem[25]), 32'h0000_F000);

    clear_fb();
    spr_mem[0] = 8'h80;
    run_draw(1'b0, 7'd1, 6'd1, 4'd1, 1'b0);
    check("lores_row2", 32'(fb_mem[16]), 32'h0000_3000);
    check("lores_row3", 32'(fb_mem[24]), 32'h0000_3000);
    check("lores_right", 32'(fb_mem[17]), 32'd0);

    clear_fb();
    spr_mem[0] = 8'hFF; spr_mem[1] = 8'hFF;
    run_draw(1'b1, 7'd124, 6'd63, 4'd2, 1'b0);
    check("edge_511", 32'(fb_mem[511]), 32'h0000_000F);
    if (Wrap) begin
      check("edge_wrap_504", 32'(fb_mem[504]), 32'h0000_F000);
      check("edge_wrap_0", 32'(fb_mem[0]), 32'h0000_F000);
      check("edge_wrap_7", 32'(fb_mem[7]), 32'h0000_000F);
    end else begin
      check("edge_clip_504", 32'(fb_mem[504]), 32'd0);
      check("edge_clip_0", 32'(fb_mem[0]), 32'd0);
      check("edge_clip_7", 32'(fb_mem[7]), 32'd0);
    end

    clear_fb();
    for (int i = 0; i < 32; i++) spr_mem[i] = 8'($urandom);
    run_draw(1'b1, 7'd20, 6'd10, 4'd3, 1'b1);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 32; i++) spr_mem[i] = 8'($urandom);
      run_draw(1'($urandom), 7'($urandom), 6'($urandom), 4'($urandom), 1'b0);
    end
    mism = 0;
    for (int i = 0; i < 512; i++) if (fb_mem[i] !== model_fb[i]) mism++;
    check("fb_contents", 32'(mism), 32'd0);

    // Abort mid-draw: writes already made are expected in order, the rest must never come.
    model_draw(1'b1, 7'd10, 6'd5, 4'd0);
    hires = 1'b1; pos_x = 7'd10; pos_y = 6'd5; rows = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    res = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_fb_we", 32'(fb_we), 32'd0);
    res = 1'b0;
    exp_wr_q.delete();
    exp_col_q.delete();
    repeat (80) tick();

    clear_fb();
    for (int i = 0; i < 32; i++) spr_mem[i] = 8'($urandom);
    run_draw(1'b0, 7'd30, 6'd7, 4'd0, 1'b0);
    mism = 0;
    for (int i = 0; i < 512; i++) if (fb_mem[i] !== model_fb[i]) mism++;
    check("fb_after_abort", 32'(mism), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
